// File: rtl/ts_capture.sv
// Dual-channel first-event timestamp capture over a fixed window.
// Feeds window-relative ts1/ts2 (0 = no event) to the comparator.
module ts_capture #(
  parameter int TS_W    = 8,
  parameter int WIN_LEN = 200
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            ev1,
  input  logic            ev2,
  output logic [TS_W-1:0] ts1,
  output logic [TS_W-1:0] ts2,
  output logic            valid,
  output logic            busy
);

  typedef enum logic {
    IDLE,
    MEAS
  } state_t;

  localparam logic [TS_W-1:0] WLEN = TS_W'(WIN_LEN);
  localparam logic [TS_W-1:0] ONE  = TS_W'(1);
  localparam logic [TS_W-1:0] ZERO = '0;

  state_t          state;
  state_t          state_n;
  logic [TS_W-1:0] cnt;
  logic [TS_W-1:0] cap1;
  logic [TS_W-1:0] cap2;
  logic            s1_a, s1_b, s1_q;
  logic            s2_a, s2_b, s2_q;
  logic            e1, e2;
  logic            last;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_a <= 1'b0;
      s1_b <= 1'b0;
      s1_q <= 1'b0;
      s2_a <= 1'b0;
      s2_b <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_a <= ev1;
      s1_b <= s1_a;
      s1_q <= s1_b;
      s2_a <= ev2;
      s2_b <= s2_a;
      s2_q <= s2_b;
    end
  end

  assign e1   = s1_b & ~s1_q;
  assign e2   = s2_b & ~s2_q;
  assign last = (state == MEAS) && (cnt == WLEN);
  assign busy = (state == MEAS);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (en) state_n = MEAS;
      MEAS: if (last && !en) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= ZERO;
      cap1  <= ZERO;
      cap2  <= ZERO;
      ts1   <= ZERO;
      ts2   <= ZERO;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en) begin
            cnt  <= ONE;
            cap1 <= ZERO;
            cap2 <= ZERO;
          end
        end
        MEAS: begin
          if (last) begin
            // an edge landing in the final cycle still counts
            valid <= 1'b1;
            ts1   <= (e1 && cap1 == ZERO) ? cnt : cap1;
            ts2   <= (e2 && cap2 == ZERO) ? cnt : cap2;
            cnt   <= en ? ONE : ZERO;
            cap1  <= ZERO;
            cap2  <= ZERO;
          end else begin
            cnt <= cnt + ONE;
            if (e1 && cap1 == ZERO) cap1 <= cnt;
            if (e2 && cap2 == ZERO) cap2 <= cnt;
          end
        end
        default: begin
          cnt <= ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ts_capture.sv
// Scoreboard bench for ts_capture with a 20-cycle window.
// Expected timestamps are queued per window and popped on valid.
module tb_ts_capture;

  localparam int TS_W = 8;
  localparam int WL   = 20;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            ev1;
  logic            ev2;
  logic [TS_W-1:0] ts1;
  logic [TS_W-1:0] ts2;
  logic            valid;
  logic            busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_pub = -1;
  bit chk_per  = 1'b0;

  typedef struct {
    int t1;
    int t2;
  } exp_t;

  exp_t sb[$];

  ts_capture #(
    .TS_W   (TS_W),
    .WIN_LEN(WL)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .ev1  (ev1),
    .ev2  (ev2),
    .ts1  (ts1),
    .ts2  (ts2),
    .valid(valid),
    .busy (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ts1", int'(ts1), e.t1);
        chk("ts2", int'(ts2), e.t2);
      end
    end
  end

  // Entered in the cnt=1 cycle; leaves in the publish cycle.
  task automatic run_win(input int a1, input int b1,
                         input int a2, input int b2,
                         input int drop,
                         input int x1, input int x2);
    exp_t e;
    e.t1 = x1;
    e.t2 = x2;
    sb.push_back(e);
    for (int c = 1; c <= WL; c++) begin
      ev1 = (c == a1) || (c == b1);
      ev2 = (c == a2) || (c == b2);
      if (c == drop) en = 1'b0;
      chk("busy_in_win", int'(busy), 1);
      if (c >= 2) chk("valid_early", int'(valid), 0);
      tick();
    end
    ev1 = 1'b0;
    ev2 = 1'b0;
    chk("valid_pub", int'(valid), 1);
    if (chk_per && last_pub >= 0)
      chk("period", cyc - last_pub, WL);
    last_pub = cyc;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    ev1 = 1'b0;
    ev2 = 1'b0;
    tick();
    tick();
    chk("rst_ts1", int'(ts1), 0);
    chk("rst_ts2", int'(ts2), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", int'(busy), 0);

    // basic capture
    en = 1'b1;
    tick();
    chk("start_busy", int'(busy), 1);
    run_win(3, 0, 10, 0, 0, 5, 12);

    // missing and repeated events
    run_win(4, 9, 0, 0, 0, 6, 0);

    // boundary events, carry into next window
    run_win(18, 0, 19, 0, 0, 20, 0);
    run_win(0, 0, 0, 0, 0, 0, 1);

    // simultaneous events, en dropped mid-window
    run_win(7, 0, 7, 0, 12, 9, 9);
    chk("drop_busy", int'(busy), 0);
    repeat (3) tick();
    chk("hold_ts1", int'(ts1), 9);
    chk("hold_ts2", int'(ts2), 9);
    chk("hold_busy", int'(busy), 0);
    chk("hold_valid", int'(valid), 0);

    // reset mid-window
    en = 1'b1;
    tick();
    chk("rw_busy", int'(busy), 1);
    for (int c = 1; c <= 10; c++) begin
      ev1 = (c >= 5);
      if (c == 10) begin
        rst = 1'b1;
        en  = 1'b0;
      end
      tick();
    end
    rst = 1'b0;
    ev1 = 1'b0;
    chk("rw_ts1", int'(ts1), 0);
    chk("rw_ts2", int'(ts2), 0);
    chk("rw_valid", int'(valid), 0);
    chk("rw_busy0", int'(busy), 0);
    repeat (WL + 2) tick();
    chk("rw_quiet_valid", int'(valid), 0);
    chk("rw_quiet_busy", int'(busy), 0);
    en = 1'b1;
    tick();
    chk("rw_restart", int'(busy), 1);

    // back-to-back windows
    chk_per  = 1'b1;
    last_pub = -1;
    run_win(2, 0, 5, 0, 0, 4, 7);
    run_win(0, 0, 3, 0, 0, 0, 5);
    run_win(11, 0, 11, 0, 0, 13, 13);
    run_win(0, 0, 0, 0, 1, 0, 0);
    chk("end_busy", int'(busy), 0);
    tick();
    tick();
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
